// File: rtl/divisor_restoring_4b.sv
// divisor_restoring_4b
//   Sequential restoring divider. A start pulse in IDLE latches num/den.
//   One quotient bit is produced per clock. A one-cycle done pulse marks
//   the point where result/rest/div_zero become valid.
//   Those outputs hold their value while a division is running, so the
//   downstream display mux never shows partial values.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous reset, active-high
//   start_i      request a division; accepted only in IDLE
//   num_i        dividend, unsigned, sampled on the accepting edge
//   den_i        divisor, unsigned, sampled on the accepting edge
//   result_o     quotient (all ones when den was 0)
//   rest_o       remainder (num when den was 0)
//   busy_o       high while iterating
//   done_o       one-cycle completion pulse
//   div_zero_o   last accepted division had den == 0

module divisor_restoring_4b #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] num_i,
    input  logic [WIDTH-1:0] den_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] rest_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q;
    logic [WIDTH:0]   a_q;        // partial remainder, one guard bit
    logic [WIDTH-1:0] q_q;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] d_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] rest_q;
    logic             busy_q;
    logic             done_q;
    logic             div_zero_q;

    // One restoring step. The extra top bit of diff acts as the borrow flag.
    logic [WIDTH+1:0] a_shift;
    logic [WIDTH+1:0] diff;
    logic             borrow;
    logic [WIDTH:0]   a_d;
    logic [WIDTH-1:0] q_d;
    logic             last_iter;

    always_comb begin
        a_shift   = {a_q, q_q[WIDTH-1]};
        diff      = a_shift - {2'b00, d_q};
        borrow    = diff[WIDTH+1];
        a_d       = borrow ? a_shift[WIDTH:0] : diff[WIDTH:0];
        q_d       = {q_q[WIDTH-2:0], ~borrow};
        last_iter = (cnt_q == CntW'(WIDTH - 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            a_q        <= '0;
            q_q        <= '0;
            d_q        <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            rest_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        d_q   <= den_i;
                        q_q   <= num_i;
                        a_q   <= '0;
                        cnt_q <= '0;
                        if (den_i == '0) begin
                            // Divide by zero finishes immediately with fixed outputs.
                            result_q   <= '1;
                            rest_q     <= num_i;
                            div_zero_q <= 1'b1;
                            done_q     <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            busy_q     <= 1'b1;
                            div_zero_q <= 1'b0;
                            state_q    <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        result_q <= q_d;
                        rest_q   <= a_d[WIDTH-1:0];
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign result_o   = result_q;
    assign rest_o     = rest_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign div_zero_o = div_zero_q;

endmodule
